// File: rtl/bus_core_pkg.sv
// Shared opcodes, ALU/branch codes, FSM encoding and branch-condition helper
// for the sequenced bus core.
package bus_core_pkg;

   localparam logic [1:0] OP_IMM = 2'b00;
   localparam logic [1:0] OP_ALU = 2'b01;
   localparam logic [1:0] OP_MOV = 2'b10;
   localparam logic [1:0] OP_BR  = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_NOT = 3'd5;
   localparam logic [2:0] ALU_SHL = 3'd6;
   localparam logic [2:0] ALU_SHR = 3'd7;

   localparam logic [2:0] BR_NEVER = 3'd0;
   localparam logic [2:0] BR_EQZ   = 3'd1;
   localparam logic [2:0] BR_LTZ   = 3'd2;
   localparam logic [2:0] BR_LEZ   = 3'd3;
   localparam logic [2:0] BR_ALWAYS = 3'd4;
   localparam logic [2:0] BR_NEZ   = 3'd5;
   localparam logic [2:0] BR_GEZ   = 3'd6;
   localparam logic [2:0] BR_GTZ   = 3'd7;

   localparam logic [2:0] REG_IO  = 3'd7;
   localparam logic [2:0] SRC_HALT = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_IN_WAIT,
      ST_OUT_WAIT,
      ST_HALT
   } state_e;

   function automatic logic br_cond(input logic [2:0] cond, input logic zero, input logic neg);
      logic hold;
      hold = 1'b0;
      case (cond)
         BR_NEVER:  hold = 1'b0;
         BR_EQZ:    hold = zero;
         BR_LTZ:    hold = neg;
         BR_LEZ:    hold = neg | zero;
         BR_ALWAYS: hold = 1'b1;
         BR_NEZ:    hold = ~zero;
         BR_GEZ:    hold = ~neg;
         BR_GTZ:    hold = ~neg & ~zero;
         default:   hold = 1'b0;
      endcase
      return hold;
   endfunction

endpackage

// File: rtl/bus_core_alu.sv
// Combinational ALU: r3 <= f(r1, r2). Results wrap to DATA_W; shifts are logical.
module bus_core_alu
   import bus_core_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [2:0]        op_i,
   output logic [DATA_W-1:0] res_o
);

   always_comb begin
      res_o = '0;
      case (op_i)
         ALU_ADD: res_o = a_i + b_i;
         ALU_SUB: res_o = a_i - b_i;
         ALU_AND: res_o = a_i & b_i;
         ALU_OR:  res_o = a_i | b_i;
         ALU_XOR: res_o = a_i ^ b_i;
         ALU_NOT: res_o = ~a_i;
         ALU_SHL: res_o = {a_i[DATA_W-2:0], 1'b0};
         ALU_SHR: res_o = {1'b0, a_i[DATA_W-1:1]};
         default: res_o = '0;
      endcase
   end

endmodule

// File: rtl/bus_core_seq.sv
// FETCH/EXEC bus core: 7 GP registers plus r7 as a valid/ready I/O port.
// Two cycles per plain instruction; I/O moves stall until the handshake completes.
module bus_core_seq
   import bus_core_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              pc_clear,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [7:0]        imem_rdata,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   input  logic [2:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_data
);

   state_e                   state_q, state_d;
   logic [ADDR_W-1:0]        pc_q, pc_d;
   logic [6:0][DATA_W-1:0]   regs_q, regs_d;
   logic [DATA_W-1:0]        out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic [2:0]               dst_q, dst_d;
   logic                     pass_q, pass_d;

   logic [1:0]        op;
   logic [2:0]        src, dst;
   logic [DATA_W-1:0] src_val, alu_res;
   logic [ADDR_W-1:0] pc_inc;
   logic              br_take;

   assign op     = imem_rdata[7:6];
   assign src    = imem_rdata[5:3];
   assign dst    = imem_rdata[2:0];
   assign pc_inc = pc_q + ADDR_W'(1);

   bus_core_alu #(.DATA_W(DATA_W)) u_alu (
      .a_i   (regs_q[1]),
      .b_i   (regs_q[2]),
      .op_i  (imem_rdata[2:0]),
      .res_o (alu_res)
   );

   // r7 reads back as the last value driven onto the output port
   always_comb begin
      src_val  = (src == REG_IO) ? out_data_q : regs_q[src];
      dbg_data = (dbg_sel == REG_IO) ? out_data_q : regs_q[dbg_sel];
   end

   assign br_take = br_cond(imem_rdata[2:0], regs_q[3] == '0, regs_q[3][DATA_W-1]);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      regs_d      = regs_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      dst_d       = dst_q;
      pass_d      = pass_q;

      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            state_d = ST_FETCH;
            pc_d    = pc_inc;
            case (op)
               OP_IMM: regs_d[0] = DATA_W'(imem_rdata[5:0]);
               OP_ALU: regs_d[3] = alu_res;
               OP_MOV: begin
                  if (src == REG_IO) begin
                     dst_d   = dst;
                     pass_d  = (dst == REG_IO);
                     pc_d    = pc_q;
                     state_d = ST_IN_WAIT;
                  end else if (dst == REG_IO) begin
                     out_data_d  = src_val;
                     out_valid_d = 1'b1;
                     pc_d        = pc_q;
                     state_d     = ST_OUT_WAIT;
                  end else begin
                     regs_d[dst] = src_val;
                  end
               end
               default: begin
                  if (src == SRC_HALT) begin
                     pc_d    = pc_q;
                     state_d = ST_HALT;
                  end else if (br_take) begin
                     pc_d = ADDR_W'(regs_q[0]);
                  end
               end
            endcase
         end
         ST_IN_WAIT: begin
            if (in_valid) begin
               if (pass_q) begin
                  out_data_d  = in_data;
                  out_valid_d = 1'b1;
                  state_d     = ST_OUT_WAIT;
               end else begin
                  regs_d[dst_q] = in_data;
                  pc_d          = pc_inc;
                  state_d       = ST_FETCH;
               end
            end
         end
         ST_OUT_WAIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               pc_d        = pc_inc;
               state_d     = ST_FETCH;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase

      // Restart abandons whatever the current instruction was doing
      if (pc_clear) begin
         state_d     = ST_IDLE;
         pc_d        = '0;
         regs_d      = regs_q;
         out_data_d  = out_data_q;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         regs_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         dst_q       <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         regs_q      <= regs_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         dst_q       <= dst_d;
         pass_q      <= pass_d;
      end
   end

   assign imem_en   = (state_q == ST_FETCH);
   assign imem_addr = pc_q;
   assign in_ready  = (state_q == ST_IN_WAIT) && in_valid && !pc_clear;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign halted    = (state_q == ST_HALT);
   assign pc        = pc_q;

endmodule
